serial_shifter: RTL



---
 rtl/serial_shifter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_shifter
//  Purpose  : Iterative sll/srl/sra unit that moves the operand one bit per
//             clock. Its results and {N,Z,C,V} flags match the combinational
//             alu. Shift amounts of WIDTH or more give the saturated result.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             start_i  - request strobe, sampled only when not busy
//             op_i     - 0=sll 1=srl 2=sra 3=reserved (passes a through)
//             a_i      - operand to shift
//             b_i      - unsigned shift amount, full width
//             busy_o   - high while shifting
//             done_o   - one-cycle pulse when res_o/flags_o are updated
//             res_o    - registered result, held until the next completion
//             flags_o  - {N,Z,C,V} of res_o
//  Revision : 1.0 - initial release
// ============================================================================
module serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o
);

  localparam int              SW      = $clog2(WIDTH);
  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   N_MAX   = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);
  localparam logic [1:0]      OP_SLL  = 2'd0;
  localparam logic [1:0]      OP_SRL  = 2'd1;
  localparam logic [1:0]      OP_SRA  = 2'd2;
  localparam logic [1:0]      OP_RSV  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [3:0]       flags_q, flags_d;

  logic [CW-1:0]    w_n;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;

  // Shifts never produce carry or overflow, so only N and Z carry information.
  function automatic logic [3:0] shift_flags(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0), 2'b00};
  endfunction

  // Effective shift count. Anything at or above WIDTH clamps to WIDTH, which
  // after WIDTH single steps leaves 0 (sll/srl) or all sign copies (sra).
  always_comb begin
    w_n = '0;
    if (op_i == OP_RSV) begin
      w_n = '0;
    end else if (b_i >= W_LIMIT) begin
      w_n = N_MAX;
    end else begin
      w_n = CW'(b_i[SW-1:0]);
    end
  end

  // One-position step of the working register for the latched operation.
  always_comb begin
    w_shifted = work_q;
    case (op_q)
      OP_SLL:  w_shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  w_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: w_shifted = work_q;
    endcase
  end

  // A new request is taken in IDLE and also in DONE, allowing back-to-back.
  assign w_accept = start_i && (state_q != S_SHIFT);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          op_d = op_i;
          if (w_n == '0) begin
            res_d   = a_i;
            flags_d = shift_flags(a_i);
            state_d = S_DONE;
          end else begin
            work_d  = a_i;
            cnt_d   = w_n;
            state_d = S_SHIFT;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = w_shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_d   = w_shifted;
          flags_d = shift_flags(w_shifted);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign busy_o  = (state_q == S_SHIFT);
  assign done_o  = (state_q == S_DONE);
  assign res_o   = res_q;
  assign flags_o = flags_q;

endmodule
`default_nettype wire
